mipi_csi2_axis_bridge: RTL and testbench

MIPI_CSI2_AXIS_BRIDGE -- requirements
Module: mipi_csi2_axis_bridge

---
 rtl/mipi_csi2_axis_bridge.sv | 132 +++++++++++++
 tb/tb_mipi_csi2_axis_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_csi2_axis_bridge.sv
// Bridges a CSI-2 decoder pixel stream onto AXI4-Stream. Start-of-frame and
// end-of-line are tagged on each beat, which then goes through a FWFT FIFO.
module mipi_csi2_axis_bridge #(
  parameter int g_DATAWIDTH     = 10,
  parameter int g_NUM_OF_PIXELS = 1,
  parameter int g_FIFO_DEPTH    = 16
) (
  input  logic                                   PARALLEL_CLOCK_I,
  input  logic                                   RESET_n_I,
  input  logic [g_NUM_OF_PIXELS*g_DATAWIDTH-1:0] data_in_i,
  input  logic                                   line_valid_i,
  input  logic                                   frame_start_i,
  input  logic                                   frame_end_i,
  output logic [g_NUM_OF_PIXELS*g_DATAWIDTH-1:0] m_axis_tdata_o,
  output logic                                   m_axis_tvalid_o,
  input  logic                                   m_axis_tready_i,
  output logic                                   m_axis_tuser_o,
  output logic                                   m_axis_tlast_o,
  output logic                                   overflow_o,
  output logic [15:0]                            line_count_o,
  output logic [15:0]                            frame_count_o
);

  localparam int W  = g_NUM_OF_PIXELS * g_DATAWIDTH;
  localparam int AW = $clog2(g_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  state_t         state, state_nxt;
  logic           hold_valid, hold_sof, sof_pending;
  logic [W-1:0]   hold_data;
  logic           capture, wr_push, wr_drop, wr_eol;
  logic [W+1:0]   mem [g_FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    mem_count;
  logic [AW+1:0]  occupancy;
  logic           fifo_full, out_load;

  // The presented output beat counts as a FIFO entry, so capacity stays g_FIFO_DEPTH.
  assign occupancy = {1'b0, mem_count} + {{(AW+1){1'b0}}, m_axis_tvalid_o};
  assign fifo_full = (occupancy == (AW+2)'(g_FIFO_DEPTH));
  assign out_load  = (mem_count != '0) && (!m_axis_tvalid_o || m_axis_tready_i);

  always_ff @(posedge PARALLEL_CLOCK_I) begin
    if (!RESET_n_I) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_start_i) state_nxt = ACTIVE;
      ACTIVE:  if (frame_start_i)    state_nxt = ACTIVE;
               else if (frame_end_i) state_nxt = IDLE;
               else if (wr_drop)     state_nxt = DROP;
      DROP:    if (frame_start_i)    state_nxt = ACTIVE;
               else if (frame_end_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_eol  = !line_valid_i || frame_start_i || frame_end_i;
    wr_push = hold_valid && !fifo_full;
    wr_drop = hold_valid && fifo_full;
    // A frame start always opens capture, even from IDLE or DROP.
    capture = line_valid_i &&
              (frame_start_i || (state == ACTIVE && !frame_end_i && !wr_drop));
  end

  always_ff @(posedge PARALLEL_CLOCK_I) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!RESET_n_I) begin
      hold_valid  <= 1'b0;
      hold_sof    <= 1'b0;
      hold_data   <= '0;
      sof_pending <= 1'b0;
    end else begin
      hold_valid <= capture;
      if (capture) begin
        hold_data <= data_in_i;
        hold_sof  <= frame_start_i || sof_pending;
      end
      if (frame_start_i) sof_pending <= !capture;
      else if (capture)  sof_pending <= 1'b0;
    end
  end

  // NOTE: storage array is not reset; validity is carried by the pointers and count.
  always_ff @(posedge PARALLEL_CLOCK_I) begin
    if (wr_push) mem[wr_ptr] <= {hold_sof, wr_eol, hold_data};
  end

  always_ff @(posedge PARALLEL_CLOCK_I) begin
    if (!RESET_n_I) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      mem_count       <= '0;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tuser_o  <= 1'b0;
      m_axis_tlast_o  <= 1'b0;
      m_axis_tdata_o  <= '0;
    end else begin
      if (wr_push)  wr_ptr <= wr_ptr + 1'b1;
      if (out_load) rd_ptr <= rd_ptr + 1'b1;
      mem_count <= mem_count + (AW+1)'(wr_push) - (AW+1)'(out_load);
      if (out_load) begin
        m_axis_tvalid_o <= 1'b1;
        {m_axis_tuser_o, m_axis_tlast_o, m_axis_tdata_o} <= mem[rd_ptr];
      end else if (m_axis_tready_i) begin
        m_axis_tvalid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge PARALLEL_CLOCK_I) begin
    if (!RESET_n_I) begin
      overflow_o    <= 1'b0;
      line_count_o  <= '0;
      frame_count_o <= '0;
    end else begin
      if (wr_drop) overflow_o <= 1'b1;
      if (frame_start_i)
        line_count_o <= '0;
      else if (wr_push && wr_eol && line_count_o != 16'hFFFF)
        line_count_o <= line_count_o + 16'd1;
      if (frame_end_i && state != IDLE) frame_count_o <= frame_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_mipi_csi2_axis_bridge.sv
// Self-checking bench for mipi_csi2_axis_bridge: directed scenarios plus
// randomized frames compared against a line/beat-level reference model.
module tb_mipi_csi2_axis_bridge;
  localparam int DW = 10, NP = 1, DEPTH = 16, W = DW * NP;

  logic         clk = 1'b0;
  logic         rst_n, lv, fs, fe, tready;
  logic [W-1:0] data_in;
  logic [W-1:0] tdata;
  logic         tvalid, tuser, tlast, overflow;
  logic [15:0]  line_count, frame_count;

  int errors = 0, checks = 0, proto_err = 0, fc_exp = 0;
  bit rand_ready = 1'b0;
  logic [W+1:0] rx [$];
  logic         prev_stall = 1'b0;
  logic [W+1:0] prev_beat;

  always #5 clk = ~clk;

  mipi_csi2_axis_bridge #(.g_DATAWIDTH(DW), .g_NUM_OF_PIXELS(NP), .g_FIFO_DEPTH(DEPTH)) dut (
    .PARALLEL_CLOCK_I(clk), .RESET_n_I(rst_n), .data_in_i(data_in),
    .line_valid_i(lv), .frame_start_i(fs), .frame_end_i(fe),
    .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid), .m_axis_tready_i(tready),
    .m_axis_tuser_o(tuser), .m_axis_tlast_o(tlast), .overflow_o(overflow),
    .line_count_o(line_count), .frame_count_o(frame_count));

  // Stream monitor: records handshakes and watches AXI stability rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(tvalid === 1'b1 && {tuser, tlast, tdata} === prev_beat))
        proto_err++;
      if (tvalid && tready) rx.push_back({tuser, tlast, tdata});
      prev_stall = tvalid && !tready;
      prev_beat  = {tuser, tlast, tdata};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f_s, input logic f_e, input logic l_v, input logic [W-1:0] d);
    fs = f_s; fe = f_e; lv = l_v; data_in = d;
    if (rand_ready) tready = ($urandom_range(0, 3) != 0);
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int cnt = 0;
    while (rx.size() < n && cnt < budget) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      cnt++;
    end
    ok = (rx.size() >= n);
    idle(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fs = 0; fe = 0; lv = 0; data_in = '0; tready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    checks++; if (tvalid !== 1'b0)     begin errors++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    checks++; if (tuser !== 1'b0)      begin errors++; $display("FAIL reset_tuser: got %b want 0", tuser); end
    checks++; if (tlast !== 1'b0)      begin errors++; $display("FAIL reset_tlast: got %b want 0", tlast); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (tdata !== '0)        begin errors++; $display("FAIL reset_tdata: got %h want 0", tdata); end
    checks++; if (line_count !== 0)    begin errors++; $display("FAIL reset_line_count: got %0d want 0", line_count); end
    checks++; if (frame_count !== 0)   begin errors++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [W+1:0] e;
    rx.delete(); tready = 1'b1;
    drive(1, 0, 0, '0);
    for (int l = 0; l < 2; l++) begin
      for (int b = 0; b < 4; b++) drive(0, 0, 1, W'(l * 4 + b + 1));
      drive(0, 0, 0, '0);
    end
    wait_rx(8, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got %0d beats want 8", rx.size()); end
    drive(0, 1, 0, '0); fc_exp++;
    idle(2);
    checks++; if (rx.size() != 8) begin errors++; $display("FAIL basic_count: got %0d want 8", rx.size()); end
    for (int i = 0; i < 8 && i < rx.size(); i++) begin
      e = {i == 0, i == 3 || i == 7, W'(i + 1)};
      checks++; if (rx[i] !== e) begin errors++; $display("FAIL basic_beat%0d: got %h want %h", i, rx[i], e); end
    end
    checks++; if (line_count !== 16'd2) begin errors++; $display("FAIL basic_line_count: got %0d want 2", line_count); end
    checks++; if (frame_count !== 16'(fc_exp)) begin errors++; $display("FAIL basic_frame_count: got %0d want %0d", frame_count, fc_exp); end
  endtask

  task automatic test_latency();
    rx.delete(); tready = 1'b1;
    drive(1, 0, 0, '0);
    checks++; if (line_count !== 16'd0) begin errors++; $display("FAIL lat_line_clear: got %0d want 0", line_count); end
    drive(0, 0, 1, 10'h3FF);          // sampled at edge N
    fs = 0; fe = 0; lv = 0; data_in = '0;
    step();                           // edge N+1
    @(negedge clk);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL lat_early: tvalid got %b want 0 at N+1", tvalid); end
    step();                           // edge N+2
    @(negedge clk);
    checks++; if (tvalid !== 1'b1 || tdata !== 10'h3FF) begin
      errors++; $display("FAIL lat_n2: got tvalid=%b tdata=%h want 1/3ff", tvalid, tdata);
    end
    checks++; if (tuser !== 1'b1 || tlast !== 1'b1) begin
      errors++; $display("FAIL lat_tags: got tuser=%b tlast=%b want 1/1", tuser, tlast);
    end
    drive(0, 1, 0, '0); fc_exp++;
    idle(3);
    checks++; if (rx.size() != 1) begin errors++; $display("FAIL lat_count: got %0d want 1", rx.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [W+1:0] e;
    rx.delete(); tready = 1'b0;
    drive(1, 0, 0, '0);
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 1, W'(i));
      if (i == 17) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_early: got %b want 0 after 16 writes", overflow); end
      end
      if (i == 18) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_set: got %b want 1 at 17th write", overflow); end
      end
    end
    idle(3);
    checks++; if (tvalid !== 1'b1 || tdata !== W'(1)) begin
      errors++; $display("FAIL bp_stall_head: got tvalid=%b tdata=%h want 1/001", tvalid, tdata);
    end
    tready = 1'b1;
    idle(30);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, W'(10'h2A0 + i));   // discarded while in DROP
    idle(6);
    drive(0, 1, 0, '0); fc_exp++;
    idle(2);
    checks++; if (rx.size() != 16) begin errors++; $display("FAIL bp_drain_count: got %0d want 16", rx.size()); end
    for (int i = 0; i < 16 && i < rx.size(); i++) begin
      e = {i == 0, 1'b0, W'(i + 1)};
      checks++; if (rx[i] !== e) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", i, rx[i], e); end
    end
    rx.delete();
    drive(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, W'(10'h150 + i));
    drive(0, 0, 0, '0);
    wait_rx(3, 50, ok);
    drive(0, 1, 0, '0); fc_exp++;
    idle(2);
    checks++; if (rx.size() != 3) begin errors++; $display("FAIL bp_next_count: got %0d want 3", rx.size()); end
    for (int i = 0; i < 3 && i < rx.size(); i++) begin
      e = {i == 0, i == 2, W'(10'h150 + i)};
      checks++; if (rx[i] !== e) begin errors++; $display("FAIL bp_next_beat%0d: got %h want %h", i, rx[i], e); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %b want 1", overflow); end
    checks++; if (frame_count !== 16'(fc_exp)) begin errors++; $display("FAIL bp_frame_count: got %0d want %0d", frame_count, fc_exp); end
  endtask

  task automatic test_no_data();
    rx.delete(); tready = 1'b1;
    drive(1, 0, 0, '0);
    idle(3);
    drive(0, 1, 0, '0); fc_exp++;
    idle(6);
    checks++; if (rx.size() != 0) begin errors++; $display("FAIL nodata_beats: got %0d want 0", rx.size()); end
    checks++; if (frame_count !== 16'(fc_exp)) begin errors++; $display("FAIL nodata_frame_count: got %0d want %0d", frame_count, fc_exp); end
  endtask

  task automatic test_restart();
    bit ok;
    logic [W+1:0] e;
    logic [W+1:0] exp_q [$];
    rx.delete(); tready = 1'b1;
    drive(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, W'(10'h011 + i));
    drive(1, 0, 1, W'(10'h014));
    checks++; if (line_count !== 16'd0) begin errors++; $display("FAIL restart_line_clear: got %0d want 0", line_count); end
    drive(0, 0, 1, W'(10'h015));
    drive(0, 0, 1, W'(10'h016));
    drive(0, 0, 0, '0);
    exp_q = '{{1'b1, 1'b0, W'(10'h011)}, {1'b0, 1'b0, W'(10'h012)}, {1'b0, 1'b1, W'(10'h013)},
              {1'b1, 1'b0, W'(10'h014)}, {1'b0, 1'b0, W'(10'h015)}, {1'b0, 1'b1, W'(10'h016)}};
    wait_rx(6, 50, ok);
    checks++; if (line_count !== 16'd1) begin errors++; $display("FAIL restart_line_count: got %0d want 1", line_count); end
    drive(0, 1, 0, '0); fc_exp++;
    idle(2);
    checks++; if (rx.size() != 6) begin errors++; $display("FAIL restart_count: got %0d want 6", rx.size()); end
    for (int i = 0; i < 6 && i < rx.size(); i++) begin
      e = exp_q[i];
      checks++; if (rx[i] !== e) begin errors++; $display("FAIL restart_beat%0d: got %h want %h", i, rx[i], e); end
    end
    checks++; if (frame_count !== 16'(fc_exp)) begin errors++; $display("FAIL restart_frame_count: got %0d want %0d", frame_count, fc_exp); end
  endtask

  task automatic test_reset_mid();
    tready = 1'b0;
    drive(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, W'(10'h0A0 + i));
    idle(4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    fc_exp = 0;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b want 0", tvalid); end
    checks++; if (line_count !== 0 || frame_count !== 0) begin
      errors++; $display("FAIL rstmid_counters: got line=%0d frame=%0d want 0/0", line_count, frame_count);
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
    tready = 1'b1; rx.delete();
    for (int i = 0; i < 8; i++) drive(0, 0, 1, W'(10'h0C0 + i));
    idle(6);
    checks++; if (rx.size() != 0 || tvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_sof: got %0d beats tvalid=%b want 0/0", rx.size(), tvalid);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [W+1:0] exp_q [$];
    logic [W-1:0] d;
    int nlines, len;
    bit coincide;
    rand_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      exp_q.delete(); rx.delete();
      nlines   = $urandom_range(1, 3);
      coincide = $urandom_range(0, 1);
      if (!coincide) drive(1, 0, 0, '0);
      for (int l = 0; l < nlines; l++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          d = W'($urandom);
          exp_q.push_back({l == 0 && b == 0, b == len - 1, d});
          drive(coincide && l == 0 && b == 0, 0, 1, d);
        end
        idle((l == nlines - 1) ? $urandom_range(0, 2) : $urandom_range(1, 2));
      end
      drive(0, 1, 0, '0); fc_exp++;
      wait_rx(exp_q.size(), 200, ok);
      checks++; if (rx.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_f%0d_count: got %0d want %0d", f, rx.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
        checks++; if (rx[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_f%0d_beat%0d: got %h want %h", f, i, rx[i], exp_q[i]);
        end
      end
      checks++; if (line_count !== 16'(nlines)) begin
        errors++; $display("FAIL rand_f%0d_lines: got %0d want %0d", f, line_count, nlines);
      end
      checks++; if (frame_count !== 16'(fc_exp)) begin
        errors++; $display("FAIL rand_f%0d_frames: got %0d want %0d", f, frame_count, fc_exp);
      end
    end
    rand_ready = 1'b0; tready = 1'b1;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow: got %b want 0", overflow); end
    checks++; if (proto_err != 0) begin errors++; $display("FAIL axis_stability: got %0d violations want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_backpressure();
    test_no_data();
    test_restart();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
